// File: rtl/div_32_iter_pkg.sv
// Shared types and constants for the iterative 32-bit signed divider.
package div_32_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIV_WIDTH  = 32;
  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = 6;

  // Most negative dividend: the one case where the quotient cannot be represented
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/div_32_iter_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = (rem_in << 1) | {{W{1'b0}}, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    // Top bit set means the trial subtraction borrowed
    q_bit   = ~diff[W];
    rem_out = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/div_32_iter.sv
// Iterative signed divider: one quotient bit per clock, sign-magnitude with truncation toward zero.
module div_32_iter
  import div_32_iter_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] data_operandA,
  input  logic [DIV_WIDTH-1:0] data_operandB,
  input  logic                 ctrl_DIV,
  output logic [DIV_WIDTH-1:0] data_result,
  output logic                 data_exception,
  output logic                 data_resultRDY
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH:0]   rem_q, rem_d;
  logic [DIV_WIDTH-1:0] quo_q, quo_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic                 neg_q, neg_d;
  logic                 ovf_q, ovf_d;
  logic [DIV_WIDTH-1:0] result_d;
  logic                 exc_d;
  logic                 rdy_d;

  logic [DIV_WIDTH:0]   step_rem;
  logic                 step_bit;
  logic [DIV_WIDTH-1:0] quo_next;
  logic [DIV_WIDTH-1:0] mag_a;
  logic [DIV_WIDTH-1:0] mag_b;

  assign mag_a    = data_operandA[DIV_WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b    = data_operandB[DIV_WIDTH-1] ? -data_operandB : data_operandB;
  // quo_q holds the unconsumed dividend in its upper bits and the quotient in its lower bits
  assign quo_next = {quo_q[DIV_WIDTH-2:0], step_bit};

  div_step #(.W(DIV_WIDTH)) u_step (
    .rem_in       (rem_q),
    .dividend_bit (quo_q[DIV_WIDTH-1]),
    .divisor      (dvs_q),
    .rem_out      (step_rem),
    .q_bit        (step_bit)
  );

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    result_d = data_result;
    exc_d    = data_exception;
    rdy_d    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (ctrl_DIV) begin
          if (data_operandB == '0) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b1;
            rdy_d    = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = mag_a;
            dvs_d   = mag_b;
            neg_d   = data_operandA[DIV_WIDTH-1] ^ data_operandB[DIV_WIDTH-1];
            ovf_d   = (data_operandA == DIV_WIDTH'(OVF_DIVIDEND)) && (data_operandB == '1);
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
          state_d  = DONE;
          result_d = neg_q ? -quo_next : quo_next;
          exc_d    = ovf_q;
          rdy_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      neg_q          <= 1'b0;
      ovf_q          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      dvs_q          <= dvs_d;
      neg_q          <= neg_d;
      ovf_q          <= ovf_d;
      data_result    <= result_d;
      data_exception <= exc_d;
      data_resultRDY <= rdy_d;
    end
  end

endmodule

// File: tb/tb_div_32_iter.sv
// Directed and random checks of div_32_iter against a scoreboard of expected quotients and timing.
module tb_div_32_iter;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          edge_n;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  div_32_iter #(.DIV_WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Reference: language division truncates toward zero; exceptions handled explicitly
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int e0);
    exp_t e;
    if (b == 32'h0) begin
      e.res = 32'h0; e.exc = 1'b1; e.edge_n = e0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000; e.exc = 1'b1; e.edge_n = e0 + 32;
    end else begin
      e.res = 32'($signed(a) / $signed(b)); e.exc = 1'b0; e.edge_n = e0 + 32;
    end
    return e;
  endfunction

  // Called just after a falling edge; the request is sampled at the next rising edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    @(negedge clock);
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int   guard;
    exp_t e;
    guard = 0;
    while (data_resultRDY !== 1'b1 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check({tag, "_rdy"}, 32'(data_resultRDY), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_edge"}, 32'(cyc), 32'(e.edge_n));
      check({tag, "_res"}, data_result, e.res);
      check({tag, "_exc"}, 32'(data_exception), 32'(e.exc));
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start(a, b);
    wait_result(tag);
    @(negedge clock);
    check({tag, "_rdy_drop"}, 32'(data_resultRDY), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int pulses;
    logic [31:0] ra;
    logic [31:0] rb;

    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'h0;
    data_operandB = 32'h0;
    repeat (3) @(negedge clock);
    check("rst_res", data_result, 32'h0);
    check("rst_exc", 32'(data_exception), 32'd0);
    check("rst_rdy", 32'(data_resultRDY), 32'd0);
    reset_n = 1'b1;

    run_div("pos_pos", 32'd100, 32'd7);
    run_div("neg_pos", -32'sd100, 32'd7);
    run_div("pos_neg", 32'd100, -32'sd7);
    run_div("neg_neg", -32'sd100, -32'sd7);
    run_div("div_zero", 32'd5, 32'd0);
    run_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("zero_dvd", 32'd0, 32'd5);
    run_div("min_by_one", 32'h8000_0000, 32'd1);
    run_div("max_by_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_div("small_big", 32'd3, 32'h8000_0000);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'h0) rb = 32'd1;
      run_div("random", ra, rb);
    end

    // Start request mid-run must be ignored
    @(negedge clock);
    start(32'd1000, 32'd10);
    repeat (9) @(negedge clock);
    data_operandA = 32'd50;
    data_operandB = 32'd5;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_result("run_ignore");
    @(negedge clock);
    check("run_ignore_drop", 32'(data_resultRDY), 32'd0);

    // Request held into DONE launches the next divide with no idle cycle
    @(negedge clock);
    start(32'd77, 32'd7);
    e0 = cyc;
    repeat (30) @(negedge clock);
    data_operandA = 32'd300;
    data_operandB = -32'sd4;
    ctrl_DIV      = 1'b1;
    sb.push_back(model(32'd300, -32'sd4, e0 + 33));
    wait_result("held_first");
    @(negedge clock);
    ctrl_DIV = 1'b0;
    check("held_gap_rdy", 32'(data_resultRDY), 32'd0);
    check("held_hold_res", data_result, 32'd11);
    wait_result("held_second");
    check("held_e65", 32'(cyc - e0), 32'd65);

    // Reset mid-run aborts without a result strobe
    @(negedge clock);
    start(32'd1000, 32'd3);
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    void'(sb.pop_front());
    check("abort_res", data_result, 32'h0);
    check("abort_exc", 32'(data_exception), 32'd0);
    check("abort_rdy", 32'(data_resultRDY), 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    run_div("after_abort", 32'd9, 32'd3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/div_32_iter.md
DIV_32_ITER -- requirements
Module: div_32_iter

Interface
REQ-001 The module SHALL have the ports below, one per line as name, direction, width, meaning.
- clock  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- data_operandA  input  32  dividend, two's complement.
- data_operandB  input  32  divisor, two's complement.
- ctrl_DIV  input  1  start request, one cycle wide, sampled on the rising edge.
- data_result  output  32  quotient, registered.
- data_exception  output  1  divide-by-zero or overflow flag, registered.
- data_resultRDY  output  1  one-cycle result-valid strobe, registered.
REQ-002 The module SHALL have one parameter: DIV_WIDTH, default 32, meaning the operand and result width.

Function
REQ-003 The module SHALL implement a state machine with three states, IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-004 On edge E0, when the state is IDLE or DONE and ctrl_DIV=1, the module SHALL latch the magnitudes of both operands, the quotient sign (A[31] XOR B[31]) and the overflow condition, then enter RUN with iteration count 0.
REQ-005 While the state is RUN, the module SHALL ignore ctrl_DIV and SHALL not re-sample data_operandA or data_operandB.
REQ-006 In RUN, each rising edge SHALL perform one restoring-division step on a 33-bit partial remainder: shift left, subtract the divisor magnitude, restore if negative, and shift in the quotient bit. Edges E1..E32 SHALL perform 32 steps in total.
REQ-007 At E32 the module SHALL enter DONE, set data_resultRDY=1, and drive data_result with the signed quotient, truncated toward zero.
REQ-008 data_resultRDY SHALL be high for exactly one cycle. At the next edge the state SHALL return to IDLE and data_resultRDY SHALL return to 0, unless ctrl_DIV=1 at that edge, in which case REQ-004 applies.
REQ-009 data_result and data_exception SHALL hold their values until the next DONE entry.
REQ-010 Divide by zero (data_operandB=0): at E0 the module SHALL enter DONE directly with data_result=0, data_exception=1 and data_resultRDY=1, giving a latency of 1 edge.
REQ-011 Overflow (A=0x80000000, B=0xFFFFFFFF): the module SHALL take the full latency and then produce data_result=0x80000000 and data_exception=1.
REQ-012 Every other division SHALL produce data_exception=0.
REQ-013 A dividend of 0 SHALL yield a result of 0 with no exception.
REQ-014 The remainder SHALL be discarded and not exposed.
REQ-015 A ctrl_DIV in DONE SHALL start a new operation in the same edge that clears data_resultRDY, so back-to-back issue costs no idle cycle.

Reset
REQ-016 When reset_n=0 is sampled on a rising edge, the module SHALL force: state=IDLE, iteration count=0, data_result=0, data_exception=0, data_resultRDY=0.
REQ-017 Reset SHALL override ctrl_DIV in the same edge.
REQ-018 Reset asserted during RUN SHALL abort the operation with no data_resultRDY pulse.

Structure
REQ-019 A shared package SHALL hold: the state encoding (IDLE, RUN, DONE), DIV_WIDTH=32, ITER_COUNT=32, and the overflow dividend constant 0x80000000.
REQ-020 The design SHALL contain one sub-module, div_step: combinational 33-bit shift-subtract-restore logic producing the next remainder and the quotient bit.
REQ-021 The iteration counter SHALL be 6 bits wide.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- 100 / 7 -> data_resultRDY=1 at E32 only, data_result=14, data_exception=0.
- -100 / 7 -> data_result=0xFFFFFFF2; 100 / -7 -> 0xFFFFFFF2; -100 / -7 -> 14.
- 5 / 0 -> data_resultRDY at E0, data_result=0, data_exception=1.
- 0x80000000 / 0xFFFFFFFF -> data_resultRDY at E32, data_result=0x80000000, data_exception=1.
- ctrl_DIV pulsed at E10 with new operands during RUN -> ignored; original quotient at E32. ctrl_DIV held during DONE -> second result at E65 relative to the first E0.
- reset_n=0 at E15 -> all outputs 0, no data_resultRDY. A following 9 / 3 -> data_result=3.
